// File: rtl/czfetch_pkg.sv
// Shared constants and types for the czfetch instruction-fetch slice.
// Widths must agree with the czpmem program ROM.
package czpkg;

   localparam int PC_WIDTH = 10;
   localparam int IR_WIDTH = 32;
   localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

   typedef struct packed {
      logic [IR_WIDTH-1:0] ir;
      logic [PC_WIDTH-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/czfetch_if.sv
// Fetch-side bus: ROM address/data, redirect/enable controls and the decode handshake.
// Handshake: an instruction transfers in any cycle where IR_VALID & IR_READY; while IR_VALID=1 and IR_READY=0 (no redirect) IR, IR_PC, IR_VALID hold.
interface czfetch_if #(
   parameter int PC_WIDTH = czpkg::PC_WIDTH,
   parameter int IR_WIDTH = czpkg::IR_WIDTH
);
   logic                EN;
   logic                BR_TAKEN;
   logic [PC_WIDTH-1:0] BR_TARGET;
   logic [PC_WIDTH-1:0] PMEM_ADDR;
   logic [IR_WIDTH-1:0] PMEM_DATA;
   logic                IR_VALID;
   logic                IR_READY;
   logic [IR_WIDTH-1:0] IR;
   logic [PC_WIDTH-1:0] IR_PC;

   modport master (
      input  EN, BR_TAKEN, BR_TARGET, PMEM_DATA, IR_READY,
      output PMEM_ADDR, IR_VALID, IR, IR_PC
   );

   modport slave (
      output EN, BR_TAKEN, BR_TARGET, PMEM_DATA, IR_READY,
      input  PMEM_ADDR, IR_VALID, IR, IR_PC
   );
endinterface

// File: rtl/czfetch_skid.sv
// One-entry holding register for ROM data that decode could not take.
// Flush beats load beats pop.
module czfetch_skid
   import czpkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  logic   pop,
   input  logic   flush,
   input  entry_t din,
   output logic   valid,
   output entry_t dout
);

   logic   valid_q, valid_d;
   entry_t entry_q, entry_d;

   always_comb begin
      valid_d = valid_q;
      entry_d = entry_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         entry_d = din;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
      end
   end

   assign valid = valid_q;
   assign dout  = entry_q;

endmodule

// File: rtl/czfetch.sv
// Instruction-fetch sequencer: owns the PC, issues one ROM read per cycle,
// tracks the in-flight read and parks stalled data in a skid entry.
module czfetch
   import czpkg::fetch_entry_t;
#(
   parameter int                  PC_WIDTH = czpkg::PC_WIDTH,
   parameter int                  IR_WIDTH = czpkg::IR_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC = czpkg::RESET_PC
) (
   input  logic      CLK,
   input  logic      RST_N,
   czfetch_if.master bus
);

   typedef struct packed {
      logic [IR_WIDTH-1:0] ir;
      logic [PC_WIDTH-1:0] pc;
   } entry_t;

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] infl_pc_q, infl_pc_d;
   logic                inflight_q, inflight_d;
   logic                issue, skid_load, skid_pop, skid_v;
   entry_t              skid_in, skid_out;

   // A stalled in-flight read blocks issue, so the skid never needs a second slot.
   always_comb begin
      issue      = bus.EN & ~skid_v & ~(inflight_q & ~bus.IR_READY);
      skid_load  = inflight_q & ~skid_v & ~bus.IR_READY;
      skid_pop   = skid_v & bus.IR_READY;
      skid_in    = '{ir: bus.PMEM_DATA, pc: infl_pc_q};
      pc_d       = pc_q;
      infl_pc_d  = infl_pc_q;
      inflight_d = 1'b0;
      if (bus.BR_TAKEN) begin
         pc_d = bus.BR_TARGET;
      end else if (issue) begin
         inflight_d = 1'b1;
         infl_pc_d  = pc_q;
         pc_d       = pc_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q       <= RESET_PC;
         inflight_q <= 1'b0;
         infl_pc_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         infl_pc_q  <= infl_pc_d;
      end
   end

   czfetch_skid #(
      .entry_t(entry_t)
   ) u_skid (
      .clk  (CLK),
      .rst_n(RST_N),
      .load (skid_load),
      .pop  (skid_pop),
      .flush(bus.BR_TAKEN),
      .din  (skid_in),
      .valid(skid_v),
      .dout (skid_out)
   );

   // Idle outputs are forced to zero rather than leaking raw ROM data.
   assign bus.PMEM_ADDR = pc_q;
   assign bus.IR_VALID  = skid_v | inflight_q;
   assign bus.IR        = skid_v ? skid_out.ir : (inflight_q ? bus.PMEM_DATA : '0);
   assign bus.IR_PC     = skid_v ? skid_out.pc : (inflight_q ? infl_pc_q : '0);

endmodule
